// File: rtl/xc_aesmix_pkg.sv
// -----------------------------------------------------------------------------
// xc_aesmix_pkg
// Shared definitions for the sequential AES MixColumns / InvMixColumns engine:
//   - GF(2^8) helpers xtime2 (multiply by 2) and xtimeN (multiply by a 4-bit
//     constant), reduction polynomial 0x11b
//   - packed MixColumns coefficient vectors, nibble n = coefficient of a_{i+n}
//   - FSM state type
// No ports (package).
// -----------------------------------------------------------------------------
package xc_aesmix_pkg;

    localparam logic [7:0]  AES_POLY = 8'h1b;

    // Nibble 0 is the coefficient applied to a_i, nibble 3 to a_{i+3}.
    localparam logic [15:0] MIX_ENC  = 16'h1132;   // {1,1,3,2}
    localparam logic [15:0] MIX_DEC  = 16'h9dbe;   // {9,d,b,e}

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Shift-and-add multiply; the constant never exceeds 4 bits.
    function automatic logic [7:0] xtimeN(input logic [7:0] b, input logic [3:0] n);
        logic [7:0] acc;
        logic [7:0] cur;
        acc = 8'h00;
        cur = b;
        for (int i = 0; i < 4; i++) begin
            if (n[i]) acc = acc ^ cur;
            cur = xtime2(cur);
        end
        return acc;
    endfunction

endpackage

// File: rtl/xc_aesmix_byte.sv
// -----------------------------------------------------------------------------
// xc_aesmix_byte
// Combinational: one output byte of MixColumns (enc) or InvMixColumns (dec)
// for one 32-bit column.
// Ports:
//   i_col  [31:0] column, byte i = bits [8i+7:8i]
//   i_row  [1:0]  output row i
//   i_enc         1 = MixColumns, 0 = InvMixColumns
//   o_byte [7:0]  r_i = sum over n of coef_n * a_{(i+n) mod 4}
// -----------------------------------------------------------------------------
module xc_aesmix_byte
    import xc_aesmix_pkg::*;
(
    input  logic [31:0] i_col,
    input  logic [1:0]  i_row,
    input  logic        i_enc,
    output logic [7:0]  o_byte
);

    logic [15:0] w_coef;
    logic [1:0]  w_idx;

    always_comb begin
        w_coef = i_enc ? MIX_ENC : MIX_DEC;
        w_idx  = 2'd0;
        o_byte = 8'h00;
        for (int n = 0; n < 4; n++) begin
            // Two-bit add wraps naturally, giving the mod-4 row rotation.
            w_idx  = i_row + 2'(n);
            o_byte = o_byte ^ xtimeN(i_col[8*w_idx +: 8], w_coef[4*n +: 4]);
        end
    end

endmodule

// File: rtl/xc_aesmix_seq.sv
// -----------------------------------------------------------------------------
// xc_aesmix_seq
// Multi-column AES MixColumns / InvMixColumns engine computing BPC result
// bytes per cycle over STEPS = 4*COLS/BPC cycles, with valid/ready on both
// sides.
// Parameters: COLS (1,2,4) columns per operation; BPC (1..16) bytes per cycle,
//             must divide 4*COLS.
// Ports:
//   clock, reset   clock; synchronous active-high reset
//   flush          abort current operation, back to IDLE
//   in_valid/in_ready, enc, din   request side (enc/din sampled at accept)
//   out_valid/out_ready, dout     result side (held until out_ready)
//   rk             round key, only with XC_AESMIX_SEQ_ROUNDKEY_EN defined;
//                  XORed into every result byte (fused AddRoundKey)
// Optional feature macro: XC_AESMIX_SEQ_ROUNDKEY_EN
// -----------------------------------------------------------------------------
module xc_aesmix_seq
    import xc_aesmix_pkg::*;
#(
    parameter int COLS = 4,
    parameter int BPC  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 enc,
    input  logic [32*COLS-1:0]   din,
`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
    input  logic [32*COLS-1:0]   rk,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*COLS-1:0]   dout
);

    localparam int STEPS = 4 * COLS / BPC;
    localparam int SW    = $clog2(STEPS) + 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SW-1:0]       r_step;
    logic                r_enc;
    logic [32*COLS-1:0]  r_din;
    logic [32*COLS-1:0]  r_res;
    logic [32*COLS-1:0]  w_key;
    logic                w_last;
    int                  w_k   [BPC];
    logic [31:0]         w_col [BPC];
    logic [1:0]          w_row [BPC];
    logic [7:0]          w_byte[BPC];

`ifdef XC_AESMIX_SEQ_ROUNDKEY_EN
    logic [32*COLS-1:0]  r_rk;
    assign w_key = r_rk;

    always_ff @(posedge clock) begin
        if (reset || flush)                      r_rk <= '0;
        else if (r_state == IDLE && in_valid)    r_rk <= rk;
    end
`else
    assign w_key = '0;
`endif

    assign w_last = (r_step == SW'(STEPS - 1));

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        dout        = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                dout      = r_res;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || flush) r_state <= IDLE;
        else                r_state <= w_state_nxt;
    end

    // Counter only advances inside RUN; any other state parks it at 0, so it
    // is already 0 whenever IDLE is entered and never reaches STEPS.
    always_ff @(posedge clock) begin
        if (reset || flush)                r_step <= '0;
        else if (r_state == RUN && !w_last) r_step <= r_step + 1'b1;
        else                               r_step <= '0;
    end

    // Operands are captured only at accept and stay frozen afterwards.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_enc <= 1'b0;
            r_din <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_enc <= enc;
            r_din <= din;
        end
    end

    // Byte k of the flattened state lives in column k/4, row k%4.
    always_comb begin
        for (int j = 0; j < BPC; j++) begin
            w_k[j]   = int'(r_step) * BPC + j;
            w_col[j] = r_din[32*(w_k[j]/4) +: 32];
            w_row[j] = w_k[j][1:0];
        end
    end

    for (genvar g = 0; g < BPC; g++) begin : g_byte
        xc_aesmix_byte u_byte (
            .i_col  (w_col[g]),
            .i_row  (w_row[g]),
            .i_enc  (r_enc),
            .o_byte (w_byte[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_res <= '0;
        end else if (r_state == RUN) begin
            for (int j = 0; j < BPC; j++)
                r_res[8*w_k[j] +: 8] <= w_byte[j] ^ w_key[8*w_k[j] +: 8];
        end
    end

endmodule
